posen_sequencer: RTL

POSEN_SEQUENCER -- requirements
Module: posen_sequencer

---
 rtl/posen_pkg.sv | 33 +++
 rtl/posen_mod360.sv | 50 +++++
 rtl/posen_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/posen_pkg.sv
// Shared types and constants for the positional-encoding sequencer.
package posen_pkg;

    localparam int unsigned MOD_ITER = 15;
    localparam int unsigned R_W      = 24;
    localparam int unsigned ANG_W    = 9;
    localparam int unsigned JW       = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MUL,
        ST_MOD,
        ST_REQ_SIN,
        ST_WAIT_SIN,
        ST_EMIT_SIN,
        ST_REQ_COS,
        ST_WAIT_COS,
        ST_EMIT_COS,
        ST_NEXT
    } state_t;

    // Degrees advanced per unit position for each sin/cos pair, Q8.
    function automatic logic [15:0] step_q8(input int unsigned k);
        case (k)
            0:       step_q8 = 16'd14668;
            1:       step_q8 = 16'd1467;
            2:       step_q8 = 16'd147;
            3:       step_q8 = 16'd15;
            default: step_q8 = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/posen_mod360.sv
// Iterative modulo-360 reducer: one conditional subtract of 360<<j per cycle, j = 14..0.
module posen_mod360
    import posen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [R_W-1:0]   value,
    output logic             done_c,
    output logic [ANG_W-1:0] result_c
);

    logic [R_W-1:0] acc;
    logic [R_W-1:0] src;
    logic [R_W-1:0] sub;
    logic [R_W-1:0] nxt;
    logic [JW-1:0]  cnt;
    logic [JW-1:0]  j;
    logic           active;

    // The start cycle already performs the j = 14 step on the incoming value.
    always_comb begin
        src      = start ? value : acc;
        j        = start ? JW'(MOD_ITER - 1) : cnt;
        sub      = R_W'(360) << j;
        nxt      = (src >= sub) ? (src - sub) : src;
        done_c   = active && (cnt == '0);
        result_c = nxt[ANG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= nxt;
            cnt    <= JW'(MOD_ITER - 2);
            active <= 1'b1;
        end else if (active) begin
            acc <= nxt;
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - JW'(1);
            end
        end
    end

endmodule

// File: rtl/posen_sequencer.sv
// Generates one sinusoidal positional-encoding vector per start using an external sine unit.
module posen_sequencer
    import posen_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FBITS   = 8,
    parameter int unsigned D_MODEL = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [15:0]                pos,
    output logic                       busy,
    output logic                       sin_start,
    output logic signed [WIDTH-1:0]    sin_angle,
    input  logic signed [WIDTH-1:0]    sin_result,
    input  logic                       sin_done,
    output logic                       pe_valid,
    input  logic                       pe_ready,
    output logic [WIDTH-1:0]           pe_data,
    output logic [$clog2(D_MODEL)-1:0] pe_idx,
    output logic                       pe_last,
    output logic                       done
);

    localparam int unsigned IW = $clog2(D_MODEL);
    localparam int unsigned KW = IW - 1;
    localparam logic [KW-1:0] LAST_K = KW'(D_MODEL / 2 - 1);

    // Sine samples pass through untouched, so FBITS only has to be sane.
    if (FBITS >= WIDTH || D_MODEL != 8) begin : g_bad_params
        $error("posen_sequencer: unsupported FBITS/D_MODEL");
    end

    state_t                   state;
    logic [15:0]              pos_q;
    logic [KW-1:0]            k;
    logic [R_W-1:0]           r_q;
    logic [R_W-1:0]           r_next;
    logic [31:0]              prod;
    logic                     mod_go;
    logic                     mod_done_c;
    logic [ANG_W-1:0]         mod_result_c;
    logic signed [WIDTH-1:0]  cos_angle;

    assign prod   = 32'(pos_q) * 32'(step_q8(32'(k)));
    assign r_next = R_W'(prod >> 8);

    always_comb begin
        if (sin_angle >= WIDTH'(270)) begin
            cos_angle = sin_angle - WIDTH'(270);
        end else begin
            cos_angle = sin_angle + WIDTH'(90);
        end
    end

    posen_mod360 u_mod360 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mod_go),
        .value    (r_q),
        .done_c   (mod_done_c),
        .result_c (mod_result_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            sin_start <= 1'b0;
            sin_angle <= '0;
            pe_valid  <= 1'b0;
            pe_data   <= '0;
            pe_idx    <= '0;
            pe_last   <= 1'b0;
            done      <= 1'b0;
            pos_q     <= '0;
            k         <= '0;
            r_q       <= '0;
            mod_go    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        pos_q <= pos;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_q    <= r_next;
                    mod_go <= 1'b1;
                    state  <= ST_MOD;
                end
                ST_MOD: begin
                    mod_go <= 1'b0;
                    if (mod_done_c) begin
                        sin_angle <= WIDTH'(mod_result_c);
                        sin_start <= 1'b1;
                        state     <= ST_REQ_SIN;
                    end
                end
                ST_REQ_SIN: begin
                    sin_start <= 1'b0;
                    state     <= ST_WAIT_SIN;
                end
                ST_WAIT_SIN: begin
                    if (sin_done) begin
                        pe_data  <= sin_result;
                        pe_idx   <= {k, 1'b0};
                        pe_last  <= 1'b0;
                        pe_valid <= 1'b1;
                        state    <= ST_EMIT_SIN;
                    end
                end
                ST_EMIT_SIN: begin
                    if (pe_ready) begin
                        pe_valid  <= 1'b0;
                        sin_angle <= cos_angle;
                        sin_start <= 1'b1;
                        state     <= ST_REQ_COS;
                    end
                end
                ST_REQ_COS: begin
                    sin_start <= 1'b0;
                    state     <= ST_WAIT_COS;
                end
                ST_WAIT_COS: begin
                    if (sin_done) begin
                        pe_data  <= sin_result;
                        pe_idx   <= {k, 1'b1};
                        pe_last  <= (k == LAST_K);
                        pe_valid <= 1'b1;
                        state    <= ST_EMIT_COS;
                    end
                end
                ST_EMIT_COS: begin
                    if (pe_ready) begin
                        pe_valid <= 1'b0;
                        pe_last  <= 1'b0;
                        if (pe_last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    k     <= k + KW'(1);
                    state <= ST_MUL;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
